ecc_scrubber: RTL and testbench

Background scrub initiator for the SECDED `ecc_ram`. It sits between the host and the RAM port and shares that port with the host, which always has priority. It walks every address at a programmable rate and reads each word. Single-bit-corrected data is written back so errors cannot accumulate into uncorrectable doubles. It also counts corrected and uncorrectable events, latches the last uncorrectable address, and pulses an interrupt.

---
 rtl/ecc_scrubber.sv | 155 +++++++++++++++
 tb/tb_ecc_scrubber.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_scrubber.sv
`default_nettype none
// ============================================================================
// Module   : ecc_scrubber
// Purpose  : background SECDED scrub initiator sharing the ecc_ram port (host has priority)
// Revision : 1.0
// ============================================================================
module ecc_scrubber #(
    parameter int DATA_WIDTH     = 8,
    parameter int RAM_DEPTH      = 256,
    parameter int SCRUB_INTERVAL = 1024,
    localparam int AW            = $clog2(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic                  host_req_i,
    input  logic                  host_we_i,
    input  logic [AW-1:0]         host_addr_i,
    input  logic [DATA_WIDTH-1:0] host_wdata_i,
    output logic [AW-1:0]         mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  mem_write_en_o,
    output logic                  mem_read_en_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_sbe_i,
    input  logic                  mem_dbe_i,
    output logic                  scrub_busy_o,
    output logic [AW-1:0]         scrub_addr_o,
    output logic [15:0]           sbe_count_o,
    output logic [15:0]           dbe_count_o,
    output logic [AW-1:0]         dbe_addr_o,
    output logic                  dbe_irq_o,
    output logic                  pass_done_o
);

    localparam int            IW        = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [IW-1:0] RELOAD    = IW'(SCRUB_INTERVAL - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);
    localparam logic [15:0]   CNT_MAX   = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ      = 3'd1,
        S_CHECK     = 3'd2,
        S_WRITEBACK = 3'd3,
        S_ADVANCE   = 3'd4
    } state_e;

    state_e                  state_q;
    logic [IW-1:0]           interval_q;
    logic [AW-1:0]           scrub_addr_q;
    logic [AW-1:0]           dbe_addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [15:0]             sbe_count_q;
    logic [15:0]             dbe_count_q;
    logic                    dbe_irq_q;
    logic                    pass_done_q;
    logic                    host_wr_hit;

    // A host write landing on the word being scrubbed makes the captured data stale.
    assign host_wr_hit = host_req_i && host_we_i && (host_addr_i == scrub_addr_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            interval_q   <= RELOAD;
            scrub_addr_q <= '0;
            dbe_addr_q   <= '0;
            wdata_q      <= '0;
            sbe_count_q  <= '0;
            dbe_count_q  <= '0;
            dbe_irq_q    <= 1'b0;
            pass_done_q  <= 1'b0;
        end else begin
            dbe_irq_q   <= 1'b0;
            pass_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!enable_i) begin
                        interval_q <= RELOAD;
                    end else if (interval_q == '0) begin
                        state_q <= S_READ;
                    end else begin
                        interval_q <= interval_q - IW'(1);
                    end
                end
                S_READ: begin
                    if (!host_req_i) begin
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (mem_sbe_i) begin
                        wdata_q <= mem_rdata_i;
                        if (sbe_count_q != CNT_MAX) begin
                            sbe_count_q <= sbe_count_q + 16'd1;
                        end
                        state_q <= host_wr_hit ? S_ADVANCE : S_WRITEBACK;
                    end else if (mem_dbe_i) begin
                        if (dbe_count_q != CNT_MAX) begin
                            dbe_count_q <= dbe_count_q + 16'd1;
                        end
                        dbe_addr_q <= scrub_addr_q;
                        dbe_irq_q  <= 1'b1;
                        state_q    <= S_ADVANCE;
                    end else begin
                        state_q <= S_ADVANCE;
                    end
                end
                S_WRITEBACK: begin
                    if (!host_req_i || host_wr_hit) begin
                        state_q <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (scrub_addr_q == LAST_ADDR) begin
                        scrub_addr_q <= '0;
                        pass_done_q  <= 1'b1;
                    end else begin
                        scrub_addr_q <= scrub_addr_q + AW'(1);
                    end
                    interval_q <= RELOAD;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Host owns the port outright whenever it requests; no added latency.
    always_comb begin
        mem_addr_o     = scrub_addr_q;
        mem_wdata_o    = wdata_q;
        mem_write_en_o = (state_q == S_WRITEBACK);
        mem_read_en_o  = (state_q == S_READ);
        if (host_req_i) begin
            mem_addr_o     = host_addr_i;
            mem_wdata_o    = host_wdata_i;
            mem_write_en_o = host_we_i;
            mem_read_en_o  = ~host_we_i;
        end
    end

    assign scrub_busy_o = (state_q != S_IDLE);
    assign scrub_addr_o = scrub_addr_q;
    assign sbe_count_o  = sbe_count_q;
    assign dbe_count_o  = dbe_count_q;
    assign dbe_addr_o   = dbe_addr_q;
    assign dbe_irq_o    = dbe_irq_q;
    assign pass_done_o  = pass_done_q;

endmodule
`default_nettype wire

// File: tb/tb_ecc_scrubber.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_scrubber
// Purpose  : directed self-checking bench for ecc_scrubber with a behavioural ecc_ram
// Revision : 1.0
// ============================================================================
module tb_ecc_scrubber;

    localparam int DW       = 8;
    localparam int DEPTH    = 4;
    localparam int INTERVAL = 2;
    localparam int AW       = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_write_en;
    logic          mem_read_en;
    logic [DW-1:0] ram_rdata = '0;
    logic          ram_sbe = 1'b0;
    logic          ram_dbe = 1'b0;
    logic          scrub_busy;
    logic [AW-1:0] scrub_addr;
    logic [15:0]   sbe_count;
    logic [15:0]   dbe_count;
    logic [AW-1:0] dbe_addr;
    logic          dbe_irq;
    logic          pass_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // RAM model: stored (true) word plus an error kind, 0 clean / 1 SBE / 2 DBE.
    logic [DW-1:0] ram_q   [DEPTH];
    logic [1:0]    ram_err [DEPTH];

    int            wr_cnt = 0;
    logic [AW-1:0] wr_addr_last = '0;
    logic [DW-1:0] wr_data_last = '0;
    int            pass_cnt = 0;
    int            irq_cnt = 0;
    int            irq_run = 0;
    int            irq_max = 0;
    int            irq_cyc = 0;
    logic [AW-1:0] addr_prev = '0;
    logic [AW-1:0] addr_log [$];
    int            rd_log [$];
    logic [AW-1:0] exp_seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    ecc_scrubber #(
        .DATA_WIDTH     (DW),
        .RAM_DEPTH      (DEPTH),
        .SCRUB_INTERVAL (INTERVAL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable_i       (enable),
        .host_req_i     (host_req),
        .host_we_i      (host_we),
        .host_addr_i    (host_addr),
        .host_wdata_i   (host_wdata),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_write_en_o (mem_write_en),
        .mem_read_en_o  (mem_read_en),
        .mem_rdata_i    (ram_rdata),
        .mem_sbe_i      (ram_sbe),
        .mem_dbe_i      (ram_dbe),
        .scrub_busy_o   (scrub_busy),
        .scrub_addr_o   (scrub_addr),
        .sbe_count_o    (sbe_count),
        .dbe_count_o    (dbe_count),
        .dbe_addr_o     (dbe_addr),
        .dbe_irq_o      (dbe_irq),
        .pass_done_o    (pass_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_read_en) begin
            ram_rdata <= (ram_err[mem_addr] == 2'd2) ? (ram_q[mem_addr] ^ 8'h03) : ram_q[mem_addr];
            ram_sbe   <= (ram_err[mem_addr] == 2'd1);
            ram_dbe   <= (ram_err[mem_addr] == 2'd2);
        end
        if (mem_write_en) begin
            ram_q[mem_addr]   = mem_wdata;
            ram_err[mem_addr] = 2'd0;
        end
    end

    always @(negedge clk) begin
        if (!host_req && mem_write_en) begin
            wr_cnt++;
            wr_addr_last = mem_addr;
            wr_data_last = mem_wdata;
        end
        if (!host_req && mem_read_en) rd_log.push_back(cyc);
        if (pass_done) pass_cnt++;
        if (dbe_irq) begin
            irq_cnt++;
            irq_run++;
            irq_cyc = cyc;
            if (irq_run > irq_max) irq_max = irq_run;
        end else begin
            irq_run = 0;
        end
        if (scrub_addr != addr_prev) begin
            addr_log.push_back(scrub_addr);
            addr_prev = scrub_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pass(input int budget);
        int n;
        n = 0;
        while (pass_done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (pass_done !== 1'b1) begin
            errors++;
            $display("FAIL pass_timeout: pass_done=%b after %0d cycles, required 1", pass_done, n);
        end
    endtask

    task automatic wait_read(input logic [AW-1:0] a, input int budget);
        int n;
        n = 0;
        while (!(!host_req && mem_read_en && mem_addr == a) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (!(mem_read_en && mem_addr == a)) begin
            errors++;
            $display("FAIL read_timeout: read_en=%b addr=%0d, required read of addr %0d", mem_read_en, mem_addr, a);
        end
    endtask

    task automatic host_read_check(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        host_req = 1'b1; host_we = 1'b0; host_addr = a;
        tick();
        host_req = 1'b0;
        checks++;
        if (ram_rdata !== exp || ram_sbe !== 1'b0) begin
            errors++;
            $display("FAIL host_read_%0d: data=%h sbe=%b, required %h sbe=0", a, ram_rdata, ram_sbe, exp);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < DEPTH; i++) begin
            ram_q[i]   = 8'h10 + 8'(i);
            ram_err[i] = 2'd0;
        end
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({scrub_busy, dbe_irq, pass_done, mem_write_en, mem_read_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy/irq/pass/we/re=%b, required 00000",
                     {scrub_busy, dbe_irq, pass_done, mem_write_en, mem_read_en});
        end
        checks++;
        if (sbe_count !== 16'd0 || dbe_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts: sbe=%h dbe=%h, required 0 0", sbe_count, dbe_count);
        end
        checks++;
        if (scrub_addr !== 2'd0 || dbe_addr !== 2'd0 || mem_addr !== 2'd0 || mem_wdata !== 8'd0) begin
            errors++;
            $display("FAIL reset_addr: scrub=%0d dbe=%0d mem=%0d wdata=%h, required all 0",
                     scrub_addr, dbe_addr, mem_addr, mem_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_clean_pass();
        int ab, rb, pb, wb;
        ab = addr_log.size(); rb = rd_log.size(); pb = pass_cnt; wb = wr_cnt;
        enable = 1'b1;
        wait_pass(60);
        enable = 1'b0;
        tick();
        checks++;
        if (addr_log.size() - ab != 4) begin
            errors++;
            $display("FAIL clean_addr_steps: %0d pointer changes, required 4", addr_log.size() - ab);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (addr_log[ab + i] !== exp_seq[i]) begin
                    errors++;
                    $display("FAIL clean_addr_seq[%0d]: %0d, required %0d", i, addr_log[ab + i], exp_seq[i]);
                end
            end
        end
        checks++;
        if (rd_log.size() - rb < 2 || rd_log[rb + 1] - rd_log[rb] != INTERVAL + 3) begin
            errors++;
            $display("FAIL clean_step_period: reads=%0d, required period %0d", rd_log.size() - rb, INTERVAL + 3);
        end
        checks++;
        if (pass_cnt - pb != 1 || pass_done !== 1'b0) begin
            errors++;
            $display("FAIL clean_pass_done: pulses=%0d now=%b, required 1 pulse then 0", pass_cnt - pb, pass_done);
        end
        checks++;
        if (sbe_count !== 16'd0 || dbe_count !== 16'd0 || wr_cnt != wb) begin
            errors++;
            $display("FAIL clean_no_events: sbe=%h dbe=%h writes=%0d, required 0 0 0", sbe_count, dbe_count, wr_cnt - wb);
        end
    endtask

    task automatic test_sbe_writeback();
        int rb, wb;
        ram_q[2] = 8'hA5; ram_err[2] = 2'd1;
        rb = rd_log.size(); wb = wr_cnt;
        enable = 1'b1;
        wait_pass(60);
        enable = 1'b0;
        tick();
        checks++;
        if (wr_cnt - wb != 1 || wr_addr_last !== 2'd2 || wr_data_last !== 8'hA5) begin
            errors++;
            $display("FAIL sbe_writeback: writes=%0d addr=%0d data=%h, required 1 2 a5", wr_cnt - wb, wr_addr_last, wr_data_last);
        end
        checks++;
        if (sbe_count !== 16'd1) begin
            errors++;
            $display("FAIL sbe_count: %0d, required 1", sbe_count);
        end
        checks++;
        if (rd_log.size() - rb < 4 || rd_log[rb + 3] - rd_log[rb + 2] != INTERVAL + 4) begin
            errors++;
            $display("FAIL sbe_step_period: reads=%0d, required period %0d", rd_log.size() - rb, INTERVAL + 4);
        end
        host_req = 1'b1; host_we = 1'b0; host_addr = 2'd2;
        #1;
        checks++;
        if (mem_read_en !== 1'b1 || mem_write_en !== 1'b0 || mem_addr !== 2'd2) begin
            errors++;
            $display("FAIL host_read_mux: re=%b we=%b addr=%0d, required 1 0 2", mem_read_en, mem_write_en, mem_addr);
        end
        host_read_check(2'd2, 8'hA5);
        checks++;
        if (sbe_count !== 16'd1) begin
            errors++;
            $display("FAIL sbe_count_after_host: %0d, required 1", sbe_count);
        end
    endtask

    task automatic test_dbe();
        int rb, wb, ib;
        ram_err[1] = 2'd2;
        ib = irq_cnt;
        host_req = 1'b1; host_we = 1'b0; host_addr = 2'd1;
        tick();
        host_req = 1'b0;
        tick();
        checks++;
        if (ram_dbe !== 1'b1 || dbe_count !== 16'd0 || irq_cnt != ib) begin
            errors++;
            $display("FAIL dbe_host_read: ram_dbe=%b dbe=%0d irqs=%0d, required 1 0 0", ram_dbe, dbe_count, irq_cnt - ib);
        end
        rb = rd_log.size(); wb = wr_cnt; ib = irq_cnt;
        enable = 1'b1;
        wait_pass(60);
        enable = 1'b0;
        tick();
        checks++;
        if (dbe_count !== 16'd1 || dbe_addr !== 2'd1) begin
            errors++;
            $display("FAIL dbe_count_addr: count=%0d addr=%0d, required 1 1", dbe_count, dbe_addr);
        end
        checks++;
        if (irq_cnt - ib != 1 || irq_max != 1) begin
            errors++;
            $display("FAIL dbe_irq_pulse: pulses=%0d max_len=%0d, required 1 1", irq_cnt - ib, irq_max);
        end
        checks++;
        if (rd_log.size() - rb < 3 || irq_cyc - rd_log[rb + 1] != 2 || rd_log[rb + 2] - rd_log[rb + 1] != INTERVAL + 3) begin
            errors++;
            $display("FAIL dbe_timing: reads=%0d, required irq 2 cycles after read and period %0d",
                     rd_log.size() - rb, INTERVAL + 3);
        end
        checks++;
        if (wr_cnt != wb || sbe_count !== 16'd1) begin
            errors++;
            $display("FAIL dbe_no_writeback: writes=%0d sbe=%0d, required 0 1", wr_cnt - wb, sbe_count);
        end
    endtask

    task automatic test_host_priority();
        int rb, pb;
        enable = 1'b1;
        wait_read(2'd0, 40);
        rb = rd_log.size(); pb = pass_cnt;
        host_req = 1'b1; host_we = 1'b1; host_addr = 2'd2; host_wdata = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (mem_addr !== 2'd2 || mem_wdata !== 8'hA5 || mem_write_en !== 1'b1 || mem_read_en !== 1'b0
                || scrub_busy !== 1'b1 || scrub_addr !== 2'd0) begin
                errors++;
                $display("FAIL host_prio_cycle%0d: addr=%0d wd=%h we=%b re=%b busy=%b ptr=%0d, required 2 a5 1 0 1 0",
                         i, mem_addr, mem_wdata, mem_write_en, mem_read_en, scrub_busy, scrub_addr);
            end
            tick();
        end
        host_req = 1'b0; host_we = 1'b0;
        enable = 1'b0;
        #1;
        checks++;
        if (mem_read_en !== 1'b1 || mem_write_en !== 1'b0 || mem_addr !== 2'd0) begin
            errors++;
            $display("FAIL host_prio_retry: re=%b we=%b addr=%0d, required 1 0 0", mem_read_en, mem_write_en, mem_addr);
        end
        tick();
        checks++;
        if (mem_read_en !== 1'b0 || rd_log.size() - rb != 1) begin
            errors++;
            $display("FAIL host_prio_check: re=%b reads=%0d, required 0 1", mem_read_en, rd_log.size() - rb);
        end
        for (int n = 0; n < 20 && scrub_busy; n++) tick();
        checks++;
        if (scrub_busy !== 1'b0 || scrub_addr !== 2'd1 || pass_cnt != pb) begin
            errors++;
            $display("FAIL host_prio_park: busy=%b ptr=%0d passes=%0d, required 0 1 0", scrub_busy, scrub_addr, pass_cnt - pb);
        end
    endtask

    task automatic test_collision();
        int wb;
        ram_err[1] = 2'd0;
        ram_q[3] = 8'h77; ram_err[3] = 2'd1;
        wb = wr_cnt;
        enable = 1'b1;
        wait_read(2'd3, 40);
        tick();
        host_req = 1'b1; host_we = 1'b1; host_addr = 2'd3; host_wdata = 8'h11;
        tick();
        host_req = 1'b0; host_we = 1'b0;
        #1;
        checks++;
        if (mem_write_en !== 1'b0) begin
            errors++;
            $display("FAIL collision_cancel: scrub write_en=%b after host write, required 0", mem_write_en);
        end
        wait_pass(10);
        enable = 1'b0;
        tick();
        checks++;
        if (wr_cnt != wb || sbe_count !== 16'd2) begin
            errors++;
            $display("FAIL collision_counts: writes=%0d sbe=%0d, required 0 2", wr_cnt - wb, sbe_count);
        end
        host_read_check(2'd3, 8'h11);
    endtask

    task automatic test_saturation_and_reset();
        int wb, n;
        dut.sbe_count_q = 16'hFFFD;
        for (int i = 0; i < 3; i++) ram_err[i] = 2'd1;
        wb = wr_cnt;
        enable = 1'b1;
        wait_pass(60);
        enable = 1'b0;
        tick();
        checks++;
        if (sbe_count !== 16'hFFFF || wr_cnt - wb != 3) begin
            errors++;
            $display("FAIL sbe_saturate: sbe=%h writes=%0d, required ffff 3", sbe_count, wr_cnt - wb);
        end
        ram_q[0] = 8'h44; ram_err[0] = 2'd1;
        wb = wr_cnt;
        enable = 1'b1;
        n = 0;
        while (!(!host_req && mem_write_en) && n < 40) begin
            tick();
            n++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_write_en !== 1'b0 || scrub_busy !== 1'b0 || sbe_count !== 16'd0 || dbe_count !== 16'd0
            || dbe_addr !== 2'd0 || scrub_addr !== 2'd0 || n >= 40) begin
            errors++;
            $display("FAIL reset_mid_wb: we=%b busy=%b sbe=%h dbe=%h dbe_addr=%0d ptr=%0d waited=%0d, required all 0 (<40)",
                     mem_write_en, scrub_busy, sbe_count, dbe_count, dbe_addr, scrub_addr, n);
        end
        repeat (2) tick();
        checks++;
        if (ram_err[0] !== 2'd1 || wr_cnt != wb) begin
            errors++;
            $display("FAIL reset_no_write: ram_err0=%0d writes=%0d, required 1 0", ram_err[0], wr_cnt - wb);
        end
        enable = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_clean_pass();
        test_sbe_writeback();
        test_dbe();
        test_host_priority();
        test_collision();
        test_saturation_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
